// File: rtl/inst_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_queue_pkg
//  Purpose  : Shared constants, types and helpers for the instruction
//             prefetch queue (default field widths, decode field offsets,
//             IR update action encoding, Count width helper).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package inst_queue_pkg;

  localparam int IW_DEF  = 10;
  localparam int OPW_DEF = 4;
  localparam int RW_DEF  = 3;

  // Decode field MSB positions for the default word layout:
  // [opcode | X | Y | unused low bits]
  localparam int OP_MSB = IW_DEF - 1;
  localparam int X_MSB  = OP_MSB - OPW_DEF;
  localparam int Y_MSB  = X_MSB - RW_DEF;

  // What the instruction register does this cycle.
  typedef enum logic [2:0] {
    IR_HOLD   = 3'd0,
    IR_FLUSH  = 3'd1,
    IR_POP    = 3'd2,
    IR_BYPASS = 3'd3,
    IR_BUBBLE = 3'd4
  } ir_act_e;

  // Count must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : inst_queue_pkg
`default_nettype wire

// File: rtl/inst_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_prefetch_queue_if
//  Purpose  : Bus bundle between the control/memory side and the prefetch
//             queue.
//  Ports    : master modport drives InstEntrada/InstValid/IRIn/Flush and
//             observes IR, decode and status; slave modport is the queue.
//  Revision : 1.0  initial release
// ============================================================================
interface inst_prefetch_queue_if #(
  parameter int IW    = 10,
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int RW    = 3
);
  import inst_queue_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic [IW-1:0]  InstEntrada;
  logic           InstValid;
  logic           IRIn;
  logic           Flush;
  logic [IW-1:0]  InstSaida;
  logic           IRValid;
  logic [OPW-1:0] Opcode;
  logic [RW-1:0]  RegX;
  logic [RW-1:0]  RegY;
  logic           QueueFull;
  logic           QueueEmpty;
  logic [CW-1:0]  Count;
  logic           Overflow;

  modport master (
    output InstEntrada, InstValid, IRIn, Flush,
    input  InstSaida, IRValid, Opcode, RegX, RegY,
    input  QueueFull, QueueEmpty, Count, Overflow
  );

  modport slave (
    input  InstEntrada, InstValid, IRIn, Flush,
    output InstSaida, IRValid, Opcode, RegX, RegY,
    output QueueFull, QueueEmpty, Count, Overflow
  );

endinterface : inst_prefetch_queue_if
`default_nettype wire

// File: rtl/inst_queue_storage.sv
`default_nettype none
// ============================================================================
//  Module   : inst_queue_storage
//  Purpose  : DEPTH x IW register array for the prefetch queue.
//  Ports    : clk_i      - clock
//             we_i       - write enable
//             waddr_i    - write pointer
//             wdata_i    - word to store
//             raddr_i    - read pointer
//             rdata_o    - asynchronous read of the entry at raddr_i
//  Revision : 1.0  initial release
// ============================================================================
module inst_queue_storage #(
  parameter int IW    = 10,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wire logic          clk_i,
  input  wire logic          we_i,
  input  wire logic [PW-1:0] waddr_i,
  input  wire logic [IW-1:0] wdata_i,
  input  wire logic [PW-1:0] raddr_i,
  output logic      [IW-1:0] rdata_o
);

  // Data entries need no reset: validity is tracked by the pointers/Count.
  logic [IW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : inst_queue_storage
`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_prefetch_queue
//  Purpose  : Instruction register fed by a DEPTH-entry prefetch FIFO, with
//             empty-queue bypass, sticky overflow and field decode.
//  Ports    : Clock  - system clock
//             Reset  - synchronous active-high reset
//             bus    - slave side of inst_prefetch_queue_if (push data,
//                      IRIn/Flush controls, IR, decode fields, status)
//  Revision : 1.0  initial release
// ============================================================================
module inst_prefetch_queue
  import inst_queue_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 4,
  parameter int OPW   = OPW_DEF,
  parameter int RW    = RW_DEF
) (
  input wire logic Clock,
  input wire logic Reset,
  inst_prefetch_queue_if.slave bus
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = cnt_w(DEPTH);
  localparam int OPMSB  = IW - 1;
  localparam int XMSB   = OPMSB - OPW;
  localparam int YMSB   = XMSB - RW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          irv_q, irv_d;
  logic          ovf_q, ovf_d;

  logic [IW-1:0] head_word;
  logic          w_empty, w_full, w_pop, w_bypass, w_push, w_drop, w_we;
  ir_act_e       w_act;

  assign w_empty  = (cnt_q == '0);
  assign w_full   = (cnt_q == FULL_CNT);
  assign w_pop    = bus.IRIn && !w_empty;
  // A bypassed word goes straight to the IR and never occupies an entry.
  assign w_bypass = bus.IRIn && w_empty && bus.InstValid;
  assign w_push   = bus.InstValid && !w_bypass && (!w_full || w_pop);
  assign w_drop   = bus.InstValid && w_full && !w_pop;
  assign w_we     = w_push && !bus.Flush;

  inst_queue_storage #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clk_i   (Clock),
    .we_i    (w_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.InstEntrada),
    .raddr_i (rptr_q),
    .rdata_o (head_word)
  );

  always_comb begin
    w_act = IR_HOLD;
    if (bus.Flush)       w_act = IR_FLUSH;
    else if (w_pop)      w_act = IR_POP;
    else if (w_bypass)   w_act = IR_BYPASS;
    else if (bus.IRIn)   w_act = IR_BUBBLE;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ir_d   = ir_q;
    irv_d  = irv_q;
    ovf_d  = ovf_q;

    if (bus.Flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (w_push) wptr_d = wptr_q + PW'(1);
      if (w_pop)  rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(w_push) - CW'(w_pop);
      if (w_drop) ovf_d = 1'b1;
    end

    case (w_act)
      IR_FLUSH: begin
        ir_d  = '0;
        irv_d = 1'b0;
      end
      IR_POP: begin
        ir_d  = head_word;
        irv_d = 1'b1;
      end
      IR_BYPASS: begin
        ir_d  = bus.InstEntrada;
        irv_d = 1'b1;
      end
      IR_BUBBLE: irv_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ir_q   <= '0;
      irv_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ir_q   <= ir_d;
      irv_q  <= irv_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.InstSaida  = ir_q;
  assign bus.IRValid    = irv_q;
  assign bus.Opcode     = ir_q[OPMSB -: OPW];
  assign bus.RegX       = ir_q[XMSB -: RW];
  assign bus.RegY       = ir_q[YMSB -: RW];
  assign bus.Count      = cnt_q;
  assign bus.QueueEmpty = w_empty;
  assign bus.QueueFull  = w_full;
  assign bus.Overflow   = ovf_q;

endmodule : inst_prefetch_queue
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_prefetch_queue
//  Purpose  : Self-checking bench for inst_prefetch_queue: directed vector
//             table, hand-written wrap sequence and random traffic checked
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_prefetch_queue;

  localparam int IW    = 10;
  localparam int DEPTH = 4;
  localparam int OPW   = 4;
  localparam int RW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_prefetch_queue_if #(.IW(IW), .DEPTH(DEPTH), .OPW(OPW), .RW(RW)) bus ();

  inst_prefetch_queue #(.IW(IW), .DEPTH(DEPTH), .OPW(OPW), .RW(RW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue plus IR/valid/overflow state.
  logic [IW-1:0] mq[$];
  logic [IW-1:0] m_ir  = '0;
  logic          m_irv = 1'b0;
  logic          m_ovf = 1'b0;

  typedef struct {
    logic          r, f, v, i;
    logic [IW-1:0] d;
    logic [IW-1:0] exp_ir;
    logic          exp_irv;
    int            exp_cnt;
    logic          exp_ovf;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic f, input logic v,
                              input logic i, input logic [IW-1:0] d);
    logic used;
    used = 1'b0;
    if (r || f) begin
      mq.delete();
      m_ir  = '0;
      m_irv = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (i) begin
        if (mq.size() > 0) begin
          m_ir  = mq.pop_front();
          m_irv = 1'b1;
        end else if (v) begin
          m_ir  = d;
          m_irv = 1'b1;
          used  = 1'b1;
        end else begin
          m_irv = 1'b0;
        end
      end
      if (v && !used) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    int n;
    n = mq.size();
    chk("m_ir",    32'(bus.InstSaida), 32'(m_ir));
    chk("m_irv",   32'(bus.IRValid),   32'(m_irv));
    chk("m_op",    32'(bus.Opcode),    32'(m_ir) / (1 << (IW - OPW)));
    chk("m_x",     32'(bus.RegX),      (32'(m_ir) / (1 << (IW - OPW - RW))) % (1 << RW));
    chk("m_y",     32'(bus.RegY),      (32'(m_ir) / (1 << (IW - OPW - 2*RW))) % (1 << RW));
    chk("m_cnt",   32'(bus.Count),     32'(n));
    chk("m_full",  32'(bus.QueueFull), 32'(n == DEPTH));
    chk("m_empty", 32'(bus.QueueEmpty),32'(n == 0));
    chk("m_ovf",   32'(bus.Overflow),  32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic apply(input logic r, input logic f, input logic v,
                       input logic i, input logic [IW-1:0] d);
    rst             = r;
    bus.Flush       = f;
    bus.InstValid   = v;
    bus.IRIn        = i;
    bus.InstEntrada = d;
    @(posedge clk);
    model_update(r, f, v, i, d);
    #1;
    model_check();
  endtask

  task automatic addv(input logic r, input logic f, input logic v, input logic i,
                      input logic [IW-1:0] d, input logic [IW-1:0] eir,
                      input logic eirv, input int ecnt, input logic eovf);
    vec_t x;
    x.r = r; x.f = f; x.v = v; x.i = i; x.d = d;
    x.exp_ir = eir; x.exp_irv = eirv; x.exp_cnt = ecnt; x.exp_ovf = eovf;
    vt.push_back(x);
  endtask

  initial begin
    logic [IW-1:0] prev, cur;
    bus.Flush = 1'b0; bus.InstValid = 1'b0; bus.IRIn = 1'b0; bus.InstEntrada = '0;

    //    r  f  v  i  data     exp_ir  irv cnt ovf
    addv(1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    for (int k = 0; k < 5; k++) addv(0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    addv(0, 0, 1, 0, 10'h2A1, 10'h000, 0, 1, 0);
    addv(0, 0, 1, 0, 10'h13F, 10'h000, 0, 2, 0);
    addv(0, 0, 1, 0, 10'h3C0, 10'h000, 0, 3, 0);
    addv(0, 0, 0, 1, 10'h000, 10'h2A1, 1, 2, 0);
    addv(0, 0, 0, 1, 10'h000, 10'h13F, 1, 1, 0);
    addv(0, 0, 0, 1, 10'h000, 10'h3C0, 1, 0, 0);
    addv(0, 0, 1, 0, 10'h111, 10'h3C0, 1, 1, 0);
    addv(0, 0, 1, 0, 10'h122, 10'h3C0, 1, 2, 0);
    addv(0, 0, 1, 0, 10'h133, 10'h3C0, 1, 3, 0);
    addv(0, 0, 1, 0, 10'h144, 10'h3C0, 1, 4, 0);
    addv(0, 0, 1, 0, 10'h155, 10'h3C0, 1, 4, 1);  // dropped
    addv(0, 0, 1, 1, 10'h166, 10'h111, 1, 4, 1);  // push+pop at full
    addv(0, 0, 0, 1, 10'h000, 10'h122, 1, 3, 1);
    addv(0, 0, 0, 1, 10'h000, 10'h133, 1, 2, 1);
    addv(0, 0, 0, 1, 10'h000, 10'h144, 1, 1, 1);
    addv(0, 0, 0, 1, 10'h000, 10'h166, 1, 0, 1);
    addv(0, 0, 1, 1, 10'h155, 10'h155, 1, 0, 1);  // bypass
    addv(0, 0, 0, 1, 10'h000, 10'h155, 0, 0, 1);  // bubble
    addv(0, 0, 1, 0, 10'h0AA, 10'h155, 0, 1, 1);
    addv(0, 0, 1, 0, 10'h0BB, 10'h155, 0, 2, 1);
    addv(0, 1, 1, 1, 10'h0CC, 10'h000, 0, 0, 0);  // flush wins
    addv(0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    addv(0, 0, 1, 0, 10'h0DD, 10'h000, 0, 1, 0);
    addv(1, 0, 1, 1, 10'h0EE, 10'h000, 0, 0, 0);  // reset mid-stream
    addv(0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);

    foreach (vt[n]) begin
      apply(vt[n].r, vt[n].f, vt[n].v, vt[n].i, vt[n].d);
      chk($sformatf("v%0d_ir", n),  32'(bus.InstSaida), 32'(vt[n].exp_ir));
      chk($sformatf("v%0d_irv", n), 32'(bus.IRValid),   32'(vt[n].exp_irv));
      chk($sformatf("v%0d_cnt", n), 32'(bus.Count),     32'(vt[n].exp_cnt));
      chk($sformatf("v%0d_ovf", n), 32'(bus.Overflow),  32'(vt[n].exp_ovf));
      chk($sformatf("v%0d_emp", n), 32'(bus.QueueEmpty),32'(vt[n].exp_cnt == 0));
      chk($sformatf("v%0d_ful", n), 32'(bus.QueueFull), 32'(vt[n].exp_cnt == DEPTH));
      if (vt[n].exp_ir == 10'h2A1) begin
        chk("dec_op", 32'(bus.Opcode), 32'hA);
        chk("dec_x",  32'(bus.RegX),   32'd4);
        chk("dec_y",  32'(bus.RegY),   32'd1);
      end
    end

    // Wrap: one word in flight, then 10 simultaneous push/pop cycles.
    prev = 10'h201;
    apply(0, 0, 1, 0, prev);
    for (int k = 0; k < 10; k++) begin
      cur = 10'(10'h210 + k * 37);
      apply(0, 0, 1, 1, cur);
      chk($sformatf("wrap%0d_ir", k),  32'(bus.InstSaida), 32'(prev));
      chk($sformatf("wrap%0d_cnt", k), 32'(bus.Count),     32'd1);
      prev = cur;
    end
    apply(0, 0, 0, 1, 10'h000);
    chk("wrap_last", 32'(bus.InstSaida), 32'(prev));

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
            IW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_prefetch_queue
`default_nettype wire
